// File: rtl/rr_stream_mux_pkg.sv
// Shared defaults and FSM encoding for the round-robin stream multiplexer.
package rr_stream_mux_pkg;

    localparam int DAT_WIDTH_DEF = 16;
    localparam int SEL_WIDTH_DEF = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } mux_state_t;

endpackage

// File: rtl/rr_stream_mux_rr_arbiter.sv
// Rotating-priority search: picks the first requester after i_rr_ptr,
// wrapping modulo NUM_WORDS, so the last-served lane has lowest priority.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter  int SEL_WIDTH = SEL_WIDTH_DEF,
    localparam int NUM_WORDS = 1 << SEL_WIDTH
) (
    input  logic [NUM_WORDS-1:0] i_req,
    input  logic [SEL_WIDTH-1:0] i_rr_ptr,
    output logic [SEL_WIDTH-1:0] o_gnt_idx,
    output logic                 o_gnt_any
);

    logic [SEL_WIDTH-1:0] w_cand [NUM_WORDS];
    logic [NUM_WORDS-1:0] w_rot_req;

    // Candidate gi is rr_ptr+gi+1; truncation to SEL_WIDTH gives the wrap.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_rot
            assign w_cand[gi]    = i_rr_ptr + SEL_WIDTH'(gi + 1);
            assign w_rot_req[gi] = i_req[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        o_gnt_idx = '0;
        for (int k = NUM_WORDS - 1; k >= 0; k--) begin
            if (w_rot_req[k]) begin
                o_gnt_idx = w_cand[k];
            end
        end
    end

    assign o_gnt_any = |i_req;

endmodule

// File: rtl/rr_stream_mux.sv
// Round-robin packet multiplexer: a granted lane keeps the output until its
// last beat is accepted; the chosen beat is registered with its lane index.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int DAT_WIDTH = DAT_WIDTH_DEF,
    parameter  int SEL_WIDTH = SEL_WIDTH_DEF,
    localparam int NUM_WORDS = 1 << SEL_WIDTH,
    localparam int TOTAL_DAT = DAT_WIDTH << SEL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TOTAL_DAT-1:0] din,
    input  logic [NUM_WORDS-1:0] din_valid,
    input  logic [NUM_WORDS-1:0] din_last,
    output logic [NUM_WORDS-1:0] din_ready,
    output logic [DAT_WIDTH-1:0] dout,
    output logic [SEL_WIDTH-1:0] dout_sel,
    output logic                 dout_last,
    output logic                 dout_valid,
    input  logic                 dout_ready
);

    mux_state_t           r_state;
    logic [SEL_WIDTH-1:0] r_rr_ptr;
    logic [SEL_WIDTH-1:0] r_lock_idx;
    logic [DAT_WIDTH-1:0] r_dout;
    logic [SEL_WIDTH-1:0] r_dout_sel;
    logic                 r_dout_last;
    logic                 r_dout_valid;

    logic [SEL_WIDTH-1:0] w_arb_idx;
    logic                 w_arb_any;
    logic [SEL_WIDTH-1:0] w_g;
    logic                 w_grant_active;
    logic                 w_load_en;
    logic                 w_accept;
    logic [DAT_WIDTH-1:0] w_lane [NUM_WORDS];

    rr_arbiter #(
        .SEL_WIDTH (SEL_WIDTH)
    ) u_arb (
        .i_req     (din_valid),
        .i_rr_ptr  (r_rr_ptr),
        .o_gnt_idx (w_arb_idx),
        .o_gnt_any (w_arb_any)
    );

    assign w_load_en      = !r_dout_valid || dout_ready;
    assign w_g            = (r_state == ST_LOCKED) ? r_lock_idx : w_arb_idx;
    assign w_grant_active = (r_state == ST_LOCKED) ? din_valid[r_lock_idx] : w_arb_any;
    assign w_accept       = w_load_en && w_grant_active;

    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_lane
            assign w_lane[gi]    = din[gi*DAT_WIDTH +: DAT_WIDTH];
            assign din_ready[gi] = w_accept && (w_g == SEL_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= SEL_WIDTH'(NUM_WORDS - 1);
            r_lock_idx   <= '0;
            r_dout       <= '0;
            r_dout_sel   <= '0;
            r_dout_last  <= 1'b0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_load_en) begin
                r_dout_valid <= w_accept;
            end
            if (w_accept) begin
                r_dout      <= w_lane[w_g];
                r_dout_sel  <= w_g;
                r_dout_last <= din_last[w_g];
                // Pointer only advances at packet boundaries, keeping fairness per packet.
                if (din_last[w_g]) begin
                    r_state  <= ST_IDLE;
                    r_rr_ptr <= w_g;
                end else begin
                    r_state    <= ST_LOCKED;
                    r_lock_idx <= w_g;
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_sel   = r_dout_sel;
    assign dout_last  = r_dout_last;
    assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: fixed stimulus steps, hand-computed results.
module tb_rr_stream_mux;

    localparam int DW = 16;
    localparam int SW = 3;
    localparam int NW = 1 << SW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW*NW-1:0] din;
    logic [NW-1:0]   din_valid;
    logic [NW-1:0]   din_last;
    logic [NW-1:0]   din_ready;
    logic [DW-1:0]   dout;
    logic [SW-1:0]   dout_sel;
    logic            dout_last;
    logic            dout_valid;
    logic            dout_ready;

    int n_vec = 0;
    int n_err = 0;

    rr_stream_mux #(.DAT_WIDTH(DW), .SEL_WIDTH(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_sel   (dout_sel),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [DW-1:0] d);
        din[i*DW +: DW] = d;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_out(input string tag, input int sel, input logic [DW-1:0] d, input logic last);
        chk({tag, ".valid"}, 32'(dout_valid), 32'd1);
        chk({tag, ".sel"},   32'(dout_sel),   32'(sel));
        chk({tag, ".dout"},  32'(dout),       32'(d));
        chk({tag, ".last"},  32'(dout_last),  32'(last));
    endtask

    initial begin
        rst_n = 1'b0; din = '0; din_valid = '0; din_last = '0; dout_ready = 1'b1;
        for (int i = 0; i < NW; i++) set_lane(i, DW'(16'hA000 + 16'(i * 16)));

        // Reset state
        step(); step();
        chk("rst.valid", 32'(dout_valid), 32'd0);
        chk("rst.dout",  32'(dout),       32'd0);
        chk("rst.sel",   32'(dout_sel),   32'd0);
        chk("rst.last",  32'(dout_last),  32'd0);
        chk("rst.ready", 32'(din_ready),  32'd0);

        // All lanes valid, single-beat packets: sequence 0..7,0
        rst_n = 1'b1; din_valid = '1; din_last = '1;
        settle();
        chk("rr.ready0", 32'(din_ready), 32'h01);
        chk("rr.latency", 32'(dout_valid), 32'd0);
        for (int k = 0; k < 9; k++) begin
            step();
            chk_out($sformatf("rr.beat%0d", k), k % NW, DW'(16'hA000 + 16'((k % NW) * 16)), 1'b1);
            chk($sformatf("rr.ready%0d", k + 1), 32'(din_ready), 32'(1 << ((k + 1) % NW)));
        end
        din_valid = '0; settle();
        step();
        chk("rr.drain", 32'(dout_valid), 32'd0);

        // Lane 2 locked 4-beat packet, lanes 3 and 5 waiting (rr_ptr=0)
        din_valid = 8'b0010_1100; din_last = 8'b0010_1000;
        for (int b = 0; b < 4; b++) begin
            set_lane(2, DW'(16'h2200 + 16'(b)));
            din_last[2] = (b == 3);
            settle();
            chk($sformatf("lock.ready%0d", b), 32'(din_ready), 32'h04);
            step();
            chk_out($sformatf("lock.beat%0d", b), 2, DW'(16'h2200 + 16'(b)), b == 3);
        end
        din_valid[2] = 1'b0; settle();
        chk("lock.ready3", 32'(din_ready), 32'h08);
        step();
        chk_out("lock.l3", 3, DW'(16'hA030), 1'b1);
        din_valid[3] = 1'b0; settle();
        chk("lock.ready5", 32'(din_ready), 32'h20);
        step();
        chk_out("lock.l5", 5, DW'(16'hA050), 1'b1);
        din_valid = '0; settle();
        step();
        chk("lock.drain", 32'(dout_valid), 32'd0);

        // Backpressure with lanes 0 and 1 valid (rr_ptr=5 -> lane 0)
        set_lane(2, DW'(16'hA020));
        din_valid = 8'b0000_0011; din_last = 8'b0000_0011;
        settle();
        chk("bp.ready0", 32'(din_ready), 32'h01);
        step();
        chk_out("bp.first", 0, DW'(16'hA000), 1'b1);
        dout_ready = 1'b0; settle();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp.hold_ready%0d", c), 32'(din_ready), 32'd0);
            step();
            chk_out($sformatf("bp.hold%0d", c), 0, DW'(16'hA000), 1'b1);
        end
        dout_ready = 1'b1; settle();
        chk("bp.release_ready", 32'(din_ready), 32'h02);
        step();
        chk_out("bp.next", 1, DW'(16'hA010), 1'b1);
        din_valid = '0; settle();
        step();
        chk("bp.drain", 32'(dout_valid), 32'd0);

        // Lane 6 packet with a 2-cycle valid gap, lane 0 waiting (rr_ptr=1)
        set_lane(6, DW'(16'h6600));
        din_valid = 8'b0100_0001; din_last = 8'b0000_0001;
        settle();
        chk("gap.ready0", 32'(din_ready), 32'h40);
        step();
        chk_out("gap.beat0", 6, DW'(16'h6600), 1'b0);
        din_valid[6] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk($sformatf("gap.hold_ready%0d", c), 32'(din_ready), 32'd0);
            step();
            chk($sformatf("gap.bubble%0d", c), 32'(dout_valid), 32'd0);
        end
        din_valid[6] = 1'b1; din_last[6] = 1'b1; set_lane(6, DW'(16'h6601));
        settle();
        chk("gap.ready1", 32'(din_ready), 32'h40);
        step();
        chk_out("gap.beat1", 6, DW'(16'h6601), 1'b1);
        din_valid[6] = 1'b0; settle();
        chk("gap.ready_l0", 32'(din_ready), 32'h01);
        step();
        chk_out("gap.l0", 0, DW'(16'hA000), 1'b1);
        din_valid = '0; settle();
        step();

        // Reset during a locked packet on lane 4 (rr_ptr=0)
        set_lane(4, DW'(16'h4400));
        din_valid = 8'b0001_0000; din_last = '0;
        step();
        chk_out("rstm.beat0", 4, DW'(16'h4400), 1'b0);
        rst_n = 1'b0;
        step();
        chk("rstm.valid", 32'(dout_valid), 32'd0);
        rst_n = 1'b1;
        din_valid = 8'b0001_0001; din_last = 8'b0000_0001;
        settle();
        chk("rstm.ready", 32'(din_ready), 32'h01);
        step();
        chk_out("rstm.l0", 0, DW'(16'hA000), 1'b1);
        din_valid[0] = 1'b0; din_last[4] = 1'b1; settle();
        chk("rstm.ready4", 32'(din_ready), 32'h10);
        step();
        chk_out("rstm.l4", 4, DW'(16'h4400), 1'b1);
        din_valid = '0; settle();
        step();

        // Wrap-around: only lane 7, then only lane 0 (rr_ptr=4)
        din_valid = 8'b1000_0000; din_last = '1;
        settle();
        chk("wrap.ready7", 32'(din_ready), 32'h80);
        step();
        chk_out("wrap.l7", 7, DW'(16'hA070), 1'b1);
        din_valid = 8'b0000_0001; settle();
        chk("wrap.ready0", 32'(din_ready), 32'h01);
        step();
        chk_out("wrap.l0", 0, DW'(16'hA000), 1'b1);
        din_valid = '1; settle();
        chk("wrap.ptr_is_0", 32'(din_ready), 32'h02);
        din_valid = '0; settle();
        chk("wrap.idle_ready", 32'(din_ready), 32'd0);
        step();
        chk("wrap.drain", 32'(dout_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
Streaming front end for the bus multiplexer path. It takes NUM_WORDS packed input lanes, each with a valid/ready/last handshake, and arbitrates between them round-robin. Once a source is granted, it keeps the grant until that source's packet ends. The selected beat is registered onto a single DAT_WIDTH output stream, together with the selected lane index.

Parameters:
DAT_WIDTH, 16, width of one data word
SEL_WIDTH, 3, lane index width
NUM_WORDS, 1<<SEL_WIDTH, number of input lanes (derived; do not override)
TOTAL_DAT, DAT_WIDTH<<SEL_WIDTH, packed input width (derived)

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  synchronous reset, active-low
din  in  TOTAL_DAT  packed lane data; lane i at bits [i*DAT_WIDTH +: DAT_WIDTH]
din_valid  in  NUM_WORDS  per-lane beat valid
din_last  in  NUM_WORDS  per-lane end-of-packet flag, qualified by din_valid
din_ready  out  NUM_WORDS  per-lane accept; at most one bit high (one-hot or zero)
dout  out  DAT_WIDTH  registered selected word
dout_sel  out  SEL_WIDTH  lane index of dout
dout_last  out  1  registered last flag
dout_valid  out  1  output beat valid
dout_ready  in  1  downstream accept

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - dout, dout_sel, dout_last = 0; dout_valid = 0.
  - FSM to IDLE; round-robin pointer rr_ptr = NUM_WORDS-1, so lane 0 has highest priority first.
- Output stage:
  - load_en = !dout_valid || dout_ready.
  - A beat is accepted from lane g when din_valid[g] && din_ready[g].
  - On acceptance, dout/dout_sel/dout_last load on the same edge and dout_valid=1.
  - Latency: 1 cycle. Throughput: 1 beat/cycle under continuous dout_ready.
  - If load_en && no acceptance: dout_valid -> 0.
  - If !load_en: output holds all fields stable.
- Grant computation (combinational):
  - IDLE: g = first lane with din_valid set, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_WORDS (wraps NUM_WORDS-1 -> 0).
  - LOCKED: g = lock_idx regardless of other requests.
- din_ready:
  - din_ready[i] = load_en && (i==g) && grant_active.
  - grant_active = any din_valid in IDLE; din_valid[lock_idx] in LOCKED.
  - din_ready may depend on din_valid. Sources must not wait for ready before asserting valid.
- FSM:
  - IDLE -> LOCKED: on accepted beat with din_last=0; lock_idx <= g.
  - IDLE -> IDLE: on accepted beat with din_last=1 (single-beat packet).
  - LOCKED -> IDLE: on accepted beat from lock_idx with din_last=1.
  - rr_ptr <= g on every accepted last beat. It is not updated on non-last beats.
- Boundary cases:
  - Locked lane drops valid mid-packet: stay LOCKED, bubble on output, all other lanes held off.
  - No valid lanes: no grant, rr_ptr unchanged.
  - Backpressure (dout_ready=0 with dout_valid=1): all din_ready=0 and the FSM does not change.
  - Simultaneous output drain and new accept: allowed in the same cycle (load_en true via dout_ready).
  - Reset mid-packet: lock dropped; any beat in the output register is discarded (dout_valid=0 after the edge).
  - din_last on a non-valid lane is ignored.

Decomposition:
- Shared package/header: SEL_WIDTH, DAT_WIDTH defaults; FSM state encodings ST_IDLE=1'b0, ST_LOCKED=1'b1.
- One sub-module, rr_arbiter:
  - Combinational rotate-priority search.
  - Inputs: req[NUM_WORDS], rr_ptr. Outputs: gnt_idx[SEL_WIDTH], gnt_any.
- Top level holds the FSM, rr_ptr, lock_idx, lane data select and output register.

Test Plan:
- Reset then all 8 lanes valid with last=1, dout_ready=1 -> dout_sel sequence 0,1,2,...,7,0 on consecutive cycles, dout = lane data, first dout_valid one cycle after first accept.
- Lane 2 sends a 4-beat packet (last on beat 4) while lanes 3 and 5 are valid -> dout_sel 2,2,2,2 then 3, then 5; din_ready[3] and din_ready[5] stay 0 during the packet.
- dout_ready low for 3 cycles with dout_valid=1 -> dout/dout_sel stable, all din_ready=0, no beats lost or duplicated after release.
- Locked lane 6 deasserts valid for 2 cycles mid-packet while lane 0 is valid -> dout_valid=0 for 2 cycles, lane 0 not granted until lane 6's last beat is accepted.
- rst_n=0 during a locked packet on lane 4 -> next cycle dout_valid=0, state IDLE; with lanes 0 and 4 valid afterwards, lane 0 is granted first.
- Only lane 7 valid, then lane 0 -> grants 7 then 0 (wrap-around), rr_ptr=0 afterwards.
